// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, control-word layout, ALU op codes and
// immediate extraction helpers used by the decode stage.
package decode_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned RIDX_W   = 5;
    localparam int unsigned CTRL_W   = 9;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Control word: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,alu_op[1:0]}
    localparam int unsigned CTRL_REG_WRITE  = 8;
    localparam int unsigned CTRL_MEM_READ   = 7;
    localparam int unsigned CTRL_MEM_WRITE  = 6;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_BRANCH     = 3;
    localparam int unsigned CTRL_JUMP       = 2;
    localparam int unsigned CTRL_ALU_OP_HI  = 1;
    localparam int unsigned CTRL_ALU_OP_LO  = 0;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_R      = 2'b10;
    localparam logic [1:0] ALU_OP_I      = 2'b11;

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:25], insn[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] insn);
        return {insn[31:12], 12'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] insn);
        return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with x0 hardwired to zero and write-through
// bypass so a same-cycle writeback is visible to the reader.
module register_file
    import decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RIDX_W-1:0] ra1,
    input  logic [RIDX_W-1:0] ra2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    input  logic              we,
    input  logic [RIDX_W-1:0] wa,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (ra1 != '0) begin
            rdata1 = (wr_en && (wa == ra1)) ? wdata : regs_q[ra1];
        end
        if (ra2 != '0) begin
            rdata2 = (wr_en && (wa == ra2)) ? wdata : regs_q[ra2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, control decode, immediate generation,
// load-use hazard detection and register file read with WB bypass.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   PC,
    input  logic [31:0]       instruction,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [RIDX_W-1:0] ex_rd,
    input  logic              wb_reg_write,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              PCWrite,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   imm,
    output logic [RIDX_W-1:0] rs1,
    output logic [RIDX_W-1:0] rs2,
    output logic [RIDX_W-1:0] rd,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [CTRL_W-1:0] ctrl
);

    logic [31:0]       ifid_insn_q;
    logic [XLEN-1:0]   ifid_pc_q;
    logic              ifid_valid_q;
    logic [6:0]        opcode;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              uses_rs2;
    logic              stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_insn_q  <= NOP_INSN;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else if (flush) begin
            ifid_insn_q  <= NOP_INSN;
            ifid_valid_q <= 1'b0;
        end else if (!stall) begin
            ifid_insn_q  <= instruction;
            ifid_pc_q    <= PC;
            ifid_valid_q <= 1'b1;
        end
    end

    assign opcode = ifid_insn_q[6:0];
    assign rd     = ifid_insn_q[11:7];
    assign funct3 = ifid_insn_q[14:12];
    assign rs1    = ifid_insn_q[19:15];
    assign rs2    = ifid_insn_q[24:20];
    assign funct7 = ifid_insn_q[31:25];
    assign id_pc  = ifid_pc_q;

    always_comb begin
        dec_ctrl = '0;
        uses_rs2 = 1'b0;
        imm      = '0;
        case (opcode)
            OP_R: begin
                dec_ctrl[CTRL_REG_WRITE] = 1'b1;
                dec_ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_R;
                uses_rs2 = 1'b1;
            end
            OP_I: begin
                dec_ctrl[CTRL_REG_WRITE] = 1'b1;
                dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
                dec_ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_I;
                imm = imm_i(ifid_insn_q);
            end
            OP_LOAD: begin
                dec_ctrl[CTRL_REG_WRITE]  = 1'b1;
                dec_ctrl[CTRL_MEM_READ]   = 1'b1;
                dec_ctrl[CTRL_MEM_TO_REG] = 1'b1;
                dec_ctrl[CTRL_ALU_SRC]    = 1'b1;
                imm = imm_i(ifid_insn_q);
            end
            OP_STORE: begin
                dec_ctrl[CTRL_MEM_WRITE] = 1'b1;
                dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
                uses_rs2 = 1'b1;
                imm = imm_s(ifid_insn_q);
            end
            OP_BRANCH: begin
                dec_ctrl[CTRL_BRANCH] = 1'b1;
                dec_ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_BRANCH;
                uses_rs2 = 1'b1;
                imm = imm_b(ifid_insn_q);
            end
            OP_JAL: begin
                dec_ctrl[CTRL_JUMP]      = 1'b1;
                dec_ctrl[CTRL_REG_WRITE] = 1'b1;
                imm = imm_j(ifid_insn_q);
            end
            OP_JALR: begin
                dec_ctrl[CTRL_JUMP]      = 1'b1;
                dec_ctrl[CTRL_REG_WRITE] = 1'b1;
                imm = imm_i(ifid_insn_q);
            end
            OP_LUI, OP_AUIPC: begin
                dec_ctrl[CTRL_REG_WRITE] = 1'b1;
                dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
                imm = imm_u(ifid_insn_q);
            end
            default: ;
        endcase
        // Writes to x0 are architecturally dead; drop them here so EX/WB never see them.
        if (rd == '0) begin
            dec_ctrl[CTRL_REG_WRITE] = 1'b0;
        end
    end

    // Load-use: the loaded value is not available until after EX's load completes.
    assign stall = ex_mem_read && (ex_rd != '0) && ifid_valid_q &&
                   ((ex_rd == rs1) || ((ex_rd == rs2) && uses_rs2));

    assign PCWrite  = !stall;
    assign id_valid = ifid_valid_q && !stall;
    assign ctrl     = id_valid ? dec_ctrl : '0;

    register_file u_register_file (
        .clk    (clk),
        .reset  (reset),
        .ra1    (rs1),
        .ra2    (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (wb_reg_write),
        .wa     (wb_rd),
        .wdata  (wb_data)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC = '0;
    logic [31:0] instruction = 32'h0000_0013;
    logic        flush = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        PCWrite;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [8:0]  ctrl;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .PC           (PC),
        .instruction  (instruction),
        .flush        (flush),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .PCWrite      (PCWrite),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .funct3       (funct3),
        .funct7       (funct7),
        .ctrl         (ctrl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (PCWrite !== 1'b1) $display("FAIL reset_pcwrite: got %b want 1", PCWrite); else passed++;
        checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", id_valid); else passed++;
        checks++; if (ctrl !== 9'h000) $display("FAIL reset_ctrl: got %h want 000", ctrl); else passed++;
        checks++; if (id_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", id_pc); else passed++;
        checks++; if (imm !== 32'h0) $display("FAIL reset_nop_imm: got %h want 0", imm); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_addi();
        instruction = 32'h0050_0093;
        PC = 32'h0000_0040;
        tick();
        checks++; if (rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", rd); else passed++;
        checks++; if (imm !== 32'd5) $display("FAIL addi_imm: got %h want 5", imm); else passed++;
        checks++; if (ctrl !== 9'h113) $display("FAIL addi_ctrl: got %h want 113", ctrl); else passed++;
        checks++; if (id_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", id_valid); else passed++;
        checks++; if (id_pc !== 32'h40) $display("FAIL addi_pc: got %h want 40", id_pc); else passed++;
    endtask

    task automatic test_wb_bypass();
        instruction = 32'h0001_01B3; // add x3,x2,x0
        PC = 32'h0000_0044;
        tick();
        checks++; if (ctrl !== 9'h102) $display("FAIL add_ctrl: got %h want 102", ctrl); else passed++;
        checks++; if (rs1_data !== 32'h0) $display("FAIL add_rs1_before_wb: got %h want 0", rs1_data); else passed++;
        wb_reg_write = 1'b1;
        wb_rd = 5'd2;
        wb_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL wb_bypass: got %h want deadbeef", rs1_data); else passed++;
        tick();
        wb_rd = 5'd0;
        wb_data = 32'h1234_5678;
        #1;
        checks++; if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL wb_stored: got %h want deadbeef", rs1_data); else passed++;
        checks++; if (rs2_data !== 32'h0) $display("FAIL x0_bypass: got %h want 0", rs2_data); else passed++;
        tick();
        wb_reg_write = 1'b0;
        #1;
        checks++; if (rs2_data !== 32'h0) $display("FAIL x0_write: got %h want 0", rs2_data); else passed++;
    endtask

    task automatic test_load_use_stall();
        instruction = 32'h0072_8333; // add x6,x5,x7
        PC = 32'h0000_0100;
        tick();
        ex_mem_read = 1'b1;
        ex_rd = 5'd5;
        instruction = 32'h0050_0093;
        PC = 32'h0000_0104;
        #1;
        checks++; if (PCWrite !== 1'b0) $display("FAIL stall_pcwrite: got %b want 0", PCWrite); else passed++;
        checks++; if (ctrl !== 9'h000) $display("FAIL stall_ctrl: got %h want 000", ctrl); else passed++;
        checks++; if (id_valid !== 1'b0) $display("FAIL stall_valid: got %b want 0", id_valid); else passed++;
        checks++; if (rd !== 5'd6) $display("FAIL stall_fields: got %0d want 6", rd); else passed++;
        tick();
        ex_mem_read = 1'b0;
        #1;
        checks++; if (id_pc !== 32'h100) $display("FAIL stall_hold_pc: got %h want 100", id_pc); else passed++;
        checks++; if (PCWrite !== 1'b1) $display("FAIL stall_release: got %b want 1", PCWrite); else passed++;
        checks++; if (ctrl !== 9'h102) $display("FAIL stall_resume_ctrl: got %h want 102", ctrl); else passed++;
        tick();
        checks++; if (id_pc !== 32'h104) $display("FAIL resume_pc: got %h want 104", id_pc); else passed++;
        checks++; if (rd !== 5'd1) $display("FAIL resume_rd: got %0d want 1", rd); else passed++;
        // addi x1,x0,5: rs2 field is 5 but unused, rs1 is x0
        ex_mem_read = 1'b1;
        ex_rd = 5'd5;
        #1;
        checks++; if (PCWrite !== 1'b1) $display("FAIL no_stall_rs2_unused: got %b want 1", PCWrite); else passed++;
        ex_rd = 5'd0;
        #1;
        checks++; if (PCWrite !== 1'b1) $display("FAIL no_stall_x0: got %b want 1", PCWrite); else passed++;
        ex_mem_read = 1'b0;
        instruction = 32'h0072_8333;
        PC = 32'h0000_0108;
        tick();
        ex_mem_read = 1'b1;
        ex_rd = 5'd7;
        #1;
        checks++; if (PCWrite !== 1'b0) $display("FAIL stall_rs2: got %b want 0", PCWrite); else passed++;
        ex_mem_read = 1'b0;
    endtask

    task automatic test_flush_over_stall();
        ex_mem_read = 1'b1;
        ex_rd = 5'd5;
        flush = 1'b1;
        instruction = 32'h0050_0093;
        PC = 32'h0000_0200;
        tick();
        flush = 1'b0;
        ex_mem_read = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", id_valid); else passed++;
        checks++; if (ctrl !== 9'h000) $display("FAIL flush_ctrl: got %h want 000", ctrl); else passed++;
        checks++; if (rd !== 5'd0 || rs1 !== 5'd0 || imm !== 32'h0)
            $display("FAIL flush_nop: got rd=%0d rs1=%0d imm=%h want 0,0,0", rd, rs1, imm); else passed++;
        checks++; if (PCWrite !== 1'b1) $display("FAIL flush_pcwrite: got %b want 1", PCWrite); else passed++;
        tick();
        checks++; if (id_pc !== 32'h200) $display("FAIL post_flush_pc: got %h want 200", id_pc); else passed++;
        checks++; if (id_valid !== 1'b1) $display("FAIL post_flush_valid: got %b want 1", id_valid); else passed++;
    endtask

    task automatic test_imm_ctrl();
        instruction = 32'hFE00_0EE3; // beq x0,x0,-4
        tick();
        checks++; if (imm !== 32'hFFFF_FFFC) $display("FAIL beq_imm: got %h want fffffffc", imm); else passed++;
        checks++; if (ctrl !== 9'h009) $display("FAIL beq_ctrl: got %h want 009", ctrl); else passed++;
        instruction = 32'hFFDF_F0EF; // jal x1,-4
        tick();
        checks++; if (imm !== 32'hFFFF_FFFC) $display("FAIL jal_imm: got %h want fffffffc", imm); else passed++;
        checks++; if (ctrl !== 9'h104) $display("FAIL jal_ctrl: got %h want 104", ctrl); else passed++;
        instruction = 32'hFE20_AC23; // sw x2,-8(x1)
        tick();
        checks++; if (imm !== 32'hFFFF_FFF8) $display("FAIL sw_imm: got %h want fffffff8", imm); else passed++;
        checks++; if (ctrl !== 9'h050) $display("FAIL sw_ctrl: got %h want 050", ctrl); else passed++;
        checks++; if (funct3 !== 3'd2) $display("FAIL sw_funct3: got %0d want 2", funct3); else passed++;
        instruction = 32'h1234_52B7; // lui x5,0x12345
        tick();
        checks++; if (imm !== 32'h1234_5000) $display("FAIL lui_imm: got %h want 12345000", imm); else passed++;
        checks++; if (ctrl !== 9'h110) $display("FAIL lui_ctrl: got %h want 110", ctrl); else passed++;
        instruction = 32'h0080_A203; // lw x4,8(x1)
        tick();
        checks++; if (ctrl !== 9'h1B0) $display("FAIL lw_ctrl: got %h want 1b0", ctrl); else passed++;
        checks++; if (imm !== 32'd8) $display("FAIL lw_imm: got %h want 8", imm); else passed++;
        instruction = 32'h0010_0013; // addi x0,x0,1
        tick();
        checks++; if (ctrl !== 9'h013) $display("FAIL rd0_ctrl: got %h want 013", ctrl); else passed++;
        instruction = 32'h4000_007F; // unknown opcode
        tick();
        checks++; if (ctrl !== 9'h000) $display("FAIL unknown_ctrl: got %h want 000", ctrl); else passed++;
        checks++; if (id_valid !== 1'b1) $display("FAIL unknown_valid: got %b want 1", id_valid); else passed++;
        checks++; if (funct7 !== 7'h20) $display("FAIL unknown_funct7: got %h want 20", funct7); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        instruction = 32'h0072_8333;
        tick();
        ex_mem_read = 1'b1;
        ex_rd = 5'd5;
        #1;
        checks++; if (PCWrite !== 1'b0) $display("FAIL pre_reset_stall: got %b want 0", PCWrite); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (PCWrite !== 1'b1) $display("FAIL reset_async_pcwrite: got %b want 1", PCWrite); else passed++;
        checks++; if (id_valid !== 1'b0) $display("FAIL reset_async_valid: got %b want 0", id_valid); else passed++;
        checks++; if (ctrl !== 9'h000) $display("FAIL reset_async_ctrl: got %h want 000", ctrl); else passed++;
        @(negedge clk);
        reset = 1'b0;
        ex_mem_read = 1'b0;
        instruction = 32'h0001_01B3; // add x3,x2,x0 -- x2 was deadbeef before reset
        tick();
        checks++; if (rs1_data !== 32'h0) $display("FAIL reset_regfile: got %h want 0", rs1_data); else passed++;
        checks++; if (id_valid !== 1'b1) $display("FAIL reset_then_load: got %b want 1", id_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_wb_bypass();
        test_load_use_stall();
        test_flush_over_stall();
        test_imm_ctrl();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
